// File: rtl/uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// uart_rx_deframer
//
// Purpose:
//   Receives a UART serial stream and recovers parallel words. A frame is a
//   start bit (0), DATA_WIDTH data bits sent LSB first, an optional parity bit,
//   and a stop bit (1). RX_IN is oversampled at PRESCALE clocks per bit and
//   sampled at mid-bit. Each frame produces either a one-cycle data_valid
//   strobe or a one-cycle error strobe. A false start produces no strobe.
//
// Parameters:
//   DATA_WIDTH  data bits per frame (2 or more)
//   PRESCALE    clk cycles per serial bit, even, 4..32
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset, dominates all inputs
//   RX_IN       in   serial line, idles high
//   par_en      in   1 = frame carries a parity bit (latched at start detect)
//   par_type    in   0 = even, 1 = odd parity (latched at start detect)
//   data_out    out  last correctly received word
//   data_valid  out  one-cycle strobe, data_out is new this cycle
//   par_err     out  one-cycle strobe, parity mismatch
//   stp_err     out  one-cycle strobe, stop bit sampled 0
//   busy        out  high while a frame is being received
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of the
//                        samples at PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1,
//                        and the decision moves one cycle later. When
//                        undefined, a single sample is taken at PRESCALE/2.
//
// FSM states:
//   state    | meaning
//   ---------+----------------------------------------------------------
//   S_IDLE   | line idle, waiting for rx_s low (start detect)
//   S_START  | inside the start bit, confirms it at mid-bit
//   S_DATA   | shifting in data bits LSB first
//   S_PARITY | sampling the parity bit
//   S_STOP   | sampling the stop bit, strobes issued the next cycle
// -----------------------------------------------------------------------------
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] CNT_PRE  = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] CNT_DEC  = CW'(PRESCALE / 2 + 1);
`else
  localparam logic [CW-1:0] CNT_DEC  = CW'(PRESCALE / 2);
`endif
  localparam logic [BW-1:0] IDX_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Synchroniser and FSM
  logic                  r_rx_meta;
  logic                  r_rx_s;
  state_t                r_state;
  state_t                w_state_nxt;

  // Bit timing
  logic [CW-1:0]         r_cnt;
  logic [BW-1:0]         r_bit_idx;

  // Frame-local data
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_type;
  logic                  r_par_bad;

  // Registered outputs
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;

  // Decoded controls
  logic                  w_dec;
  logic                  w_bit;
  logic                  w_last_bit;
  logic                  w_par_exp;
  logic                  w_busy;
  logic                  w_start_det;
  logic                  w_shift_en;
  logic                  w_par_smp;
  logic                  w_stop_smp;

  // ---------------------------------------------------------------------------
  // Input synchroniser; resets to the idle level so a reset never looks like
  // a start bit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= RX_IN;
      r_rx_s    <= r_rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit value at the decision cycle
  // ---------------------------------------------------------------------------
  assign w_dec = (r_cnt == CNT_DEC);

`ifdef UART_RX_MAJORITY_EN
  logic r_smp_pre;
  logic r_smp_mid;

  // The first two of the three samples are held; the third is the live rx_s
  // in the decision cycle itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_smp_pre <= 1'b1;
      r_smp_mid <= 1'b1;
    end else begin
      if (r_cnt == CNT_PRE) r_smp_pre <= r_rx_s;
      if (r_cnt == CNT_MID) r_smp_mid <= r_rx_s;
    end
  end

  assign w_bit = (r_smp_pre & r_smp_mid) |
                 (r_smp_pre & r_rx_s)    |
                 (r_smp_mid & r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  assign w_last_bit = (r_bit_idx == IDX_LAST);
  assign w_par_exp  = (^r_shift) ^ r_par_type;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (!r_rx_s) w_state_nxt = S_START;
      S_START:  if (w_dec)   w_state_nxt = w_bit ? S_IDLE : S_DATA;
      S_DATA:   if (w_dec && w_last_bit)
                  w_state_nxt = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_dec)   w_state_nxt = S_STOP;
      S_STOP:   if (w_dec)   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_busy      = 1'b0;
    w_start_det = 1'b0;
    w_shift_en  = 1'b0;
    w_par_smp   = 1'b0;
    w_stop_smp  = 1'b0;
    case (r_state)
      S_IDLE:   w_start_det = ~r_rx_s;
      S_START:  w_busy      = 1'b1;
      S_DATA: begin
        w_busy     = 1'b1;
        w_shift_en = w_dec;
      end
      S_PARITY: begin
        w_busy    = 1'b1;
        w_par_smp = w_dec;
      end
      S_STOP: begin
        w_busy     = 1'b1;
        w_stop_smp = w_dec;
      end
      default: w_busy = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bit timer. The start-detect cycle is cnt = 0, so the first START cycle
  // carries cnt = 1. Whenever the FSM heads back to IDLE the timer is cleared
  // so the next start edge is measured from zero.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (w_state_nxt == S_IDLE) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= CW'(1);
    end else if (r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_idx <= '0;
    end else if (w_start_det) begin
      r_bit_idx <= '0;
    end else if (w_shift_en) begin
      r_bit_idx <= w_last_bit ? '0 : r_bit_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame datapath and registered strobes
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_type   <= 1'b0;
      r_par_bad    <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
    end else begin
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;

      // Parity settings are frozen per frame so mid-frame changes are ignored.
      if (w_start_det) begin
        r_par_en   <= par_en;
        r_par_type <= par_type;
        r_par_bad  <= 1'b0;
      end

      // LSB arrives first, so new bits enter at the top and shift down.
      if (w_shift_en) r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};

      if (w_par_smp) r_par_bad <= (w_bit != w_par_exp);

      // Both error strobes may fire together; data_out only moves on a
      // clean frame.
      if (w_stop_smp) begin
        r_stp_err <= ~w_bit;
        r_par_err <= r_par_bad;
        if (w_bit && !r_par_bad) begin
          r_data_valid <= 1'b1;
          r_data_out   <= r_shift;
        end
      end
    end
  end

  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;
  assign par_err    = r_par_err;
  assign stp_err    = r_stp_err;
  assign busy       = w_busy;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// -----------------------------------------------------------------------------
// Bench for uart_rx_deframer (DATA_WIDTH=8, PRESCALE=8).
// The whole stimulus is laid out cycle by cycle before the run starts. Each
// scheduled frame also writes the expected outputs for every cycle, derived
// from the frame format and the stated latency:
//   start detect  = cycle RX_IN falls + 2 (synchroniser)
//   strobe        = start detect + (N-1)*P + DEC + 1, N = 2 + DW + par_en
//   busy          = high from start detect + 1 up to the cycle before strobe
// A stop error leaves rx_s low when IDLE is re-entered, which the block treats
// as a new start that then fails at its mid-bit check (busy for DEC cycles).
// -----------------------------------------------------------------------------
module tb_uart_rx_deframer;

  localparam int DW   = 8;
  localparam int P    = 8;
`ifdef UART_RX_MAJORITY_EN
  localparam int DEC  = P / 2 + 1;
  localparam bit MAJ  = 1'b1;
`else
  localparam int DEC  = P / 2;
  localparam bit MAJ  = 1'b0;
`endif
  localparam int MAXC = 12000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          RX_IN = 1'b1;
  logic          par_en = 1'b0;
  logic          par_type = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          busy;

  uart_rx_deframer #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .clk        (clk),
    .rst        (rst),
    .RX_IN      (RX_IN),
    .par_en     (par_en),
    .par_type   (par_type),
    .data_out   (data_out),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Stimulus per cycle
  bit         line_a [MAXC];
  bit         rst_a  [MAXC];
  bit         pe_a   [MAXC];
  bit         pt_a   [MAXC];
  // Expected outputs per cycle
  bit         e_dv   [MAXC];
  bit         e_pe   [MAXC];
  bit         e_se   [MAXC];
  bit         e_busy [MAXC];
  bit         e_clr  [MAXC];
  logic [7:0] e_word [MAXC];
  // Observed outputs per cycle
  logic [7:0] o_dout [MAXC];
  logic       o_dv   [MAXC];
  logic       o_pe   [MAXC];
  logic       o_se   [MAXC];
  logic       o_busy [MAXC];

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cur   = 0;
  int         total = 0;
  logic [7:0] m_dout = 8'h00;

  task automatic chk(input string nm, input int c, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", nm, c, act, exp);
    end
  endtask

  // Lays out one frame starting at line cycle k and its expected outputs.
  task automatic sched_frame(input int k, input logic [7:0] d, input bit pe,
                             input bit pt, input bit bad_par, input bit bad_stop,
                             input logic [7:0] exp_w, output int fin);
    int nb;
    int det;
    int lat;
    bit pbit;
    bit pbad;
    pbad = pe && bad_par;
    nb   = 2 + DW + (pe ? 1 : 0);
    for (int i = 0; i < P; i++) line_a[k + i] = 1'b0;
    for (int b = 0; b < DW; b++)
      for (int i = 0; i < P; i++) line_a[k + (1 + b) * P + i] = d[b];
    if (pe) begin
      pbit = (^d) ^ pt ^ pbad;
      for (int i = 0; i < P; i++) line_a[k + (1 + DW) * P + i] = pbit;
    end
    for (int i = 0; i < P; i++) line_a[k + (nb - 1) * P + i] = !bad_stop;
    for (int i = k + 1; i <= k + 3; i++) begin
      pe_a[i] = pe;
      pt_a[i] = pt;
    end
    det = k + 2;
    lat = (nb - 1) * P + DEC + 1;
    for (int c = det + 1; c < det + lat; c++) e_busy[c] = 1'b1;
    e_dv[det + lat]   = !pbad && !bad_stop;
    e_pe[det + lat]   = pbad;
    e_se[det + lat]   = bad_stop;
    e_word[det + lat] = exp_w;
    fin = k + nb * P;
    if (bad_stop) begin
      for (int c = det + lat + 1; c <= det + lat + DEC; c++) e_busy[c] = 1'b1;
      fin = fin + P;
    end
  endtask

  task automatic sched_false(input int k, input int w, output int fin);
    for (int i = 0; i < w; i++) line_a[k + i] = 1'b0;
    for (int c = k + 3; c <= k + 2 + DEC; c++) e_busy[c] = 1'b1;
    fin = k + 2 * P;
  endtask

  // Reset driven in cycle r takes effect in cycle r+1; the line is held idle
  // for the rest of the abandoned frame.
  task automatic sched_reset(input int r, input int span);
    rst_a[r]     = 1'b1;
    e_clr[r + 1] = 1'b1;
    for (int c = r; c <= r + span; c++) line_a[c] = 1'b1;
    for (int c = r + 1; c <= r + span; c++) begin
      e_busy[c] = 1'b0;
      e_dv[c]   = 1'b0;
      e_pe[c]   = 1'b0;
      e_se[c]   = 1'b0;
    end
  endtask

  always @(negedge clk) begin : cmp
    int c;
    c = cur;
    if (c >= 1) begin
      if (e_clr[c]) m_dout = 8'h00;
      if (e_dv[c])  m_dout = e_word[c];
      chk("data_valid", c, data_valid, e_dv[c]);
      chk("par_err",    c, par_err,    e_pe[c]);
      chk("stp_err",    c, stp_err,    e_se[c]);
      chk("busy",       c, busy,       e_busy[c]);
      chk("data_out",   c, data_out,   m_dout);
      o_dout[c] = data_out;
      o_dv[c]   = data_valid;
      o_pe[c]   = par_err;
      o_se[c]   = stp_err;
      o_busy[c] = busy;
    end
  end

  initial begin
    int k, fin, k0, fs_k, r_k, rnd_start, cnt, first;
    logic [7:0] pin_vals [7];
    logic [7:0] d;
    bit pe, pt, bp, bs;

    for (int c = 0; c < MAXC; c++) begin
      line_a[c] = 1'b1;
      pe_a[c]   = 1'($urandom_range(0, 1));
      pt_a[c]   = 1'($urandom_range(0, 1));
      e_word[c] = 8'h00;
      o_dv[c]   = 1'b0;
      o_pe[c]   = 1'b0;
      o_se[c]   = 1'b0;
      o_busy[c] = 1'b0;
    end
    for (int c = 0; c < 3; c++) begin
      rst_a[c]     = 1'b1;
      e_clr[c + 1] = 1'b1;
    end

    // Directed sequence
    k0 = 10;
    sched_frame(k0, 8'hA5, 0, 0, 0, 0, 8'hA5, fin);  k = fin + 5;
    sched_frame(k, 8'h3C, 1, 0, 1, 0, 8'h3C, fin);   k = fin + 3;
    sched_frame(k, 8'h3C, 1, 0, 0, 0, 8'h3C, fin);   k = fin;
    sched_frame(k, 8'h5A, 0, 0, 0, 1, 8'h5A, fin);   k = fin;
    sched_frame(k, 8'h81, 0, 0, 0, 0, 8'h81, fin);   k = fin + 4;
    fs_k = k;
    sched_false(k, 3, fin);                          k = fin;
    sched_frame(k, 8'hC3, 0, 0, 0, 0, 8'hC3, fin);   k = fin;
    sched_frame(k, 8'h7E, 0, 0, 0, 0, 8'h7E, fin);   k = fin;
    sched_frame(k, 8'h99, 0, 0, 0, 0, 8'h99, fin);
    r_k = k + 30;
    sched_reset(r_k, 120);                           k = r_k + 130;
    sched_frame(k, 8'h11, 0, 0, 0, 0, 8'h11, fin);   k = fin + 6;
    sched_frame(k, 8'h00, 0, 0, 0, 0, MAJ ? 8'h00 : 8'h08, fin);
    line_a[k + 4 * P + P / 2] = 1'b1;
    k = fin + 6;
    rnd_start = k;

    // Random frames, back-to-back allowed
    for (int n = 0; n < 45; n++) begin
      if (k > MAXC - 300) break;
      if ($urandom_range(0, 9) == 0) begin
        sched_false(k, $urandom_range(1, DEC - 1), fin);
      end else begin
        d  = 8'($urandom);
        pe = 1'($urandom_range(0, 1));
        pt = 1'($urandom_range(0, 1));
        bp = ($urandom_range(0, 4) == 0);
        bs = ($urandom_range(0, 5) == 0);
        sched_frame(k, d, pe, pt, bp, bs, d, fin);
      end
      k = fin + (($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12));
    end
    total = k + 40;

    // Play the stimulus
    for (int c = 0; c < total; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      cur      = c;
      RX_IN    = line_a[c];
      rst      = rst_a[c];
      par_en   = pe_a[c];
      par_type = pt_a[c];
    end
    @(negedge clk);
    #1;

    // Hand-computed expectations for the directed part
    pin_vals = '{8'hA5, 8'h3C, 8'h81, 8'hC3, 8'h7E, 8'h11, (MAJ ? 8'h00 : 8'h08)};
    first = -1;
    cnt   = 0;
    for (int c = 1; c < rnd_start; c++) begin
      if (o_dv[c] === 1'b1) begin
        if (first < 0) first = c;
        if (cnt < 7) chk("pin_word", c, o_dout[c], pin_vals[cnt]);
        cnt++;
      end
    end
    chk("pin_dv_count", rnd_start, cnt, 7);
    chk("pin_latency", first, first - (k0 + 2), MAJ ? 78 : 77);

    first = -1;
    for (int c = 1; c < rnd_start && first < 0; c++)
      if (o_pe[c] === 1'b1) first = c;
    chk("pin_parerr_seen", first, (first > 0) ? 1 : 0, 1);
    if (first > 0) begin
      chk("pin_parerr_hold", first, o_dout[first], 8'hA5);
      chk("pin_parerr_nodv", first, o_dv[first], 1'b0);
    end

    first = -1;
    for (int c = 1; c < rnd_start && first < 0; c++)
      if (o_se[c] === 1'b1) first = c;
    chk("pin_stperr_seen", first, (first > 0) ? 1 : 0, 1);
    if (first > 0) chk("pin_stperr_hold", first, o_dout[first], 8'h3C);

    cnt = 0;
    for (int c = fs_k; c < fs_k + 2 * P; c++)
      if (o_busy[c] === 1'b1) cnt++;
    chk("pin_false_busy", fs_k, cnt, MAJ ? 5 : 4);

    chk("pin_rst_dout", r_k + 1, o_dout[r_k + 1], 8'h00);
    chk("pin_rst_busy", r_k + 1, o_busy[r_k + 1], 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
